// File: rtl/move_sequencer.sv
// ---------------------------------------------------------------------------
// move_sequencer
// Sequences the heading PID datapath for a single move command. A move
// turns the robot in place until the heading error settles. It then ramps
// forward speed up while counting centre-line crossings, and decelerates
// to a stop once the requested distance has been covered.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   go           one-cycle move request (ignored while busy)
//   hdg_in[11:0] desired heading, latched on an accepted go
//   sqrs[3:0]    squares to travel; two line crossings per square
//   heading_rdy  one-cycle pulse marking a fresh error sample
//   error[11:0]  signed heading error from the datapath
//   cntrIR       centre-line sensor level (already synchronised)
//   moving       PID enable
//   frwrd[9:0]   ramped forward speed to the PID
//   dsrd_hdg     latched heading reference
//   busy         move in progress
//   done         one-cycle completion pulse
// ---------------------------------------------------------------------------
module move_sequencer #(
  parameter logic [9:0]  FRWRD_INC = 10'h020,
  parameter logic [9:0]  FRWRD_MAX = 10'h2C0,
  parameter logic [11:0] TURN_TOL  = 12'h030
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [11:0] hdg_in,
  input  logic [3:0]  sqrs,
  input  logic        heading_rdy,
  input  logic [11:0] error,
  input  logic        cntrIR,
  output logic        moving,
  output logic [9:0]  frwrd,
  output logic [11:0] dsrd_hdg,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TURN  = 2'd1;
  localparam logic [1:0] RAMP  = 2'd2;
  localparam logic [1:0] DECEL = 2'd3;

  // Deceleration is twice as aggressive as the ramp-up.
  localparam logic [10:0] DEC_STEP = {FRWRD_INC, 1'b0};

  logic [1:0]  r_state;
  logic [1:0]  w_nextState;
  logic [4:0]  r_target;
  logic [4:0]  r_crossCnt;
  logic        r_cntrSeen;
  logic        r_cntrPrev;
  logic [9:0]  r_frwrd;
  logic [11:0] r_dsrdHdg;
  logic        r_busy;
  logic        r_done;

  logic [11:0] w_absErr;
  logic        w_turnDone;
  logic        w_rise;
  logic [10:0] w_rampSum;
  logic [9:0]  w_rampNext;
  logic [9:0]  w_decelNext;

  // Magnitude of the heading error. The most negative code has no positive
  // twin in 12 bits, so it is clamped to the largest positive value.
  always_comb begin
    w_absErr = error;
    if (error == 12'h800) begin
      w_absErr = 12'h7FF;
    end else if (error[11]) begin
      w_absErr = ~error + 12'd1;
    end
  end

  // The sum uses one spare bit, so a speed near the ceiling cannot wrap
  // before it is clamped.
  always_comb begin
    w_turnDone  = heading_rdy && (w_absErr < TURN_TOL);
    w_rise      = r_cntrSeen & ~r_cntrPrev;
    w_rampSum   = {1'b0, r_frwrd} + {1'b0, FRWRD_INC};
    w_rampNext  = (w_rampSum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : w_rampSum[9:0];
    w_decelNext = ({1'b0, r_frwrd} > DEC_STEP) ? (r_frwrd - DEC_STEP[9:0]) : 10'd0;
  end

  // Next-state logic. In RAMP, distance completion is checked every cycle,
  // independent of heading_rdy. A zero-square move finishes straight from
  // TURN.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (go) w_nextState = TURN;
      TURN:    if (w_turnDone) w_nextState = (r_target == 5'd0) ? IDLE : RAMP;
      RAMP:    if (r_crossCnt == r_target) w_nextState = DECEL;
      DECEL:   if (heading_rdy && (r_frwrd == 10'd0)) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register, with busy/moving and done registered from the next
  // state. This keeps every output a clean flop. done fires only on a
  // natural return to IDLE, never on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_busy  <= (w_nextState != IDLE);
      r_done  <= (r_state != IDLE) && (w_nextState == IDLE);
    end
  end

  // Two-flop history of the line sensor. It tracks the sensor in every
  // state, so a line that is already high when RAMP starts never looks like
  // a fresh rise. The rise is taken from the registered pair, which is why a
  // crossing is counted one cycle after it is first sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cntrSeen <= 1'b0;
      r_cntrPrev <= 1'b0;
    end else begin
      r_cntrSeen <= cntrIR;
      r_cntrPrev <= r_cntrSeen;
    end
  end

  // Move parameters, crossing counter and speed profile. The heading
  // reference keeps its value after the move completes. Crossings count only
  // in RAMP, and the count stops at 31.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frwrd    <= 10'd0;
      r_dsrdHdg  <= 12'd0;
      r_target   <= 5'd0;
      r_crossCnt <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_frwrd <= 10'd0;
          if (go) begin
            r_dsrdHdg  <= hdg_in;
            r_target   <= {sqrs, 1'b0};
            r_crossCnt <= 5'd0;
          end
        end
        RAMP: begin
          if (heading_rdy) r_frwrd <= w_rampNext;
          if (w_rise && (r_crossCnt != 5'd31)) r_crossCnt <= r_crossCnt + 5'd1;
        end
        DECEL: begin
          if (heading_rdy && (r_frwrd != 10'd0)) r_frwrd <= w_decelNext;
        end
        default: begin
        end
      endcase
    end
  end

  assign moving   = r_busy;
  assign busy     = r_busy;
  assign done     = r_done;
  assign frwrd    = r_frwrd;
  assign dsrd_hdg = r_dsrdHdg;

endmodule

// File: tb/tb_move_sequencer.sv
// ---------------------------------------------------------------------------
// tb_move_sequencer
// Directed bench for move_sequencer. An abstract model of a move is
// advanced on every clock edge, and the DUT outputs are compared against it
// on every falling edge. Hand-computed literals pin the key points of each
// scenario.
// ---------------------------------------------------------------------------
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic [11:0] hdg_in;
  logic [3:0]  sqrs;
  logic        heading_rdy;
  logic [11:0] error;
  logic        cntrIR;
  logic        moving;
  logic [9:0]  frwrd;
  logic [11:0] dsrd_hdg;
  logic        busy;
  logic        done;

  int  vectors     = 0;
  int  miscompares = 0;
  bit  checkEn     = 1'b0;

  move_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .hdg_in      (hdg_in),
    .sqrs        (sqrs),
    .heading_rdy (heading_rdy),
    .error       (error),
    .cntrIR      (cntrIR),
    .moving      (moving),
    .frwrd       (frwrd),
    .dsrd_hdg    (dsrd_hdg),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Abstract move model. The phase of the move is kept as a small integer.
  // Speeds are plain integers with the profile constants written out: a step
  // of 32 up, 64 down, and a ceiling of 704. The line history mirrors the
  // one-cycle sensing delay of the sequencer.
  localparam int M_IDLE  = 0;
  localparam int M_TURN  = 1;
  localparam int M_RAMP  = 2;
  localparam int M_DECEL = 3;

  int          mMode  = M_IDLE;
  int          mSpeed = 0;
  int          mGoal  = 0;
  int          mCross = 0;
  logic [11:0] mHdg   = 12'd0;
  bit          mDone  = 1'b0;
  bit          mIrNow = 1'b0;
  bit          mIrOld = 1'b0;

  always @(posedge clk) begin : model
    int errVal;
    int errMag;
    bit lineRise;
    if (!rst_n) begin
      mMode  = M_IDLE;
      mSpeed = 0;
      mGoal  = 0;
      mCross = 0;
      mHdg   = 12'd0;
      mDone  = 1'b0;
      mIrNow = 1'b0;
      mIrOld = 1'b0;
    end else begin
      errVal   = $signed(error);
      errMag   = (errVal < 0) ? -errVal : errVal;
      if (errMag > 2047) errMag = 2047;
      lineRise = mIrNow && !mIrOld;
      mDone    = 1'b0;
      case (mMode)
        M_IDLE: if (go) begin
          mHdg   = hdg_in;
          mGoal  = 2 * int'(sqrs);
          mCross = 0;
          mMode  = M_TURN;
        end
        M_TURN: if (heading_rdy && errMag < 48) begin
          if (mGoal == 0) begin
            mMode = M_IDLE;
            mDone = 1'b1;
          end else begin
            mMode = M_RAMP;
          end
        end
        M_RAMP: begin
          if (heading_rdy) mSpeed = (mSpeed + 32 > 704) ? 704 : mSpeed + 32;
          if (mCross == mGoal) mMode = M_DECEL;
          if (lineRise && mCross < 31) mCross++;
        end
        default: if (heading_rdy) begin
          if (mSpeed == 0) begin
            mMode = M_IDLE;
            mDone = 1'b1;
          end else begin
            mSpeed = (mSpeed > 64) ? mSpeed - 64 : 0;
          end
        end
      endcase
      mIrOld = mIrNow;
      mIrNow = cntrIR;
    end
  end

  // Compares every DUT output against the model, once per cycle.
  task automatic checkOutput();
    logic [24:0] act;
    logic [24:0] exp;
    act = {moving, busy, done, frwrd, dsrd_hdg};
    exp = {(mMode != M_IDLE), (mMode != M_IDLE), mDone, 10'(mSpeed), mHdg};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL cycle t=%0t: got mv=%b bz=%b dn=%b fw=%h hd=%h, expected mv=%b bz=%b dn=%b fw=%h hd=%h",
               $time, act[24], act[23], act[22], act[21:12], act[11:0],
               exp[24], exp[23], exp[22], exp[21:12], exp[11:0]);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) checkOutput();
  end

  // Checks one hand-computed literal.
  task automatic expectLit(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of stimulus. go and heading_rdy are single-cycle
  // pulses; cntrIR is a level that stays as left.
  task automatic applyStimulus(input bit goV, input bit hrV, input bit irV);
    go          = goV;
    heading_rdy = hrV;
    cntrIR      = irV;
    tick();
    go          = 1'b0;
    heading_rdy = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0; go = 1'b0; hdg_in = 12'd0; sqrs = 4'd0;
    heading_rdy = 1'b0; error = 12'd0; cntrIR = 1'b0;

    // Reset state
    tick();
    checkEn = 1'b1;
    tick();
    expectLit("rst_frwrd", 16'(frwrd), 16'h0);
    expectLit("rst_flags", 16'({moving, busy, done}), 16'h0);
    expectLit("rst_hdg", 16'(dsrd_hdg), 16'h0);
    rst_n = 1'b1;
    tick();

    // Turn-only move: no squares, done right after the heading settles
    hdg_in = 12'h3FF; sqrs = 4'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectLit("go_busy", 16'({moving, busy}), 16'h3);
    expectLit("go_hdg", 16'(dsrd_hdg), 16'h3FF);
    error = 12'h100;
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectLit("turn_hold", 16'(busy), 16'h1);
    error = 12'h02F;
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectLit("turn_done", 16'({busy, done}), 16'h1);
    expectLit("turn_frwrd", 16'(frwrd), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectLit("done_once", 16'(done), 16'h0);

    // One square: boundary errors, ignored go, line high across RAMP entry
    hdg_in = 12'h123; sqrs = 4'd1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    error = 12'h800;
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectLit("err800_turn", 16'({busy, frwrd}), 16'h400);
    error = 12'hFD0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    hdg_in = 12'h555; sqrs = 4'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectLit("go_busy_ign", 16'(dsrd_hdg), 16'h123);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    error = 12'h000;
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    expectLit("ramp_10", 16'(frwrd), 16'h140);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    // heading_rdy on the DECEL-entry edge still ramps up
    applyStimulus(1'b0, 1'b1, 1'b1);
    expectLit("decel_entry_inc", 16'(frwrd), 16'h160);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectLit("decel_first", 16'(frwrd), 16'h120);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    expectLit("dist_idle", 16'({busy, frwrd}), 16'h0);
    expectLit("dist_hdg_held", 16'(dsrd_hdg), 16'h123);

    // Ramp saturation, then a reset in the middle of the move
    hdg_in = 12'h7AB; sqrs = 4'd3; error = 12'h000;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectLit("ramp_first", 16'(frwrd), 16'h020);
    for (int i = 0; i < 29; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    expectLit("ramp_sat", 16'(frwrd), 16'h2C0);
    rst_n = 1'b0;
    tick();
    tick();
    expectLit("abort_outs", 16'({moving, busy, done, frwrd}), 16'h0);
    rst_n = 1'b1;
    tick();
    expectLit("abort_no_done", 16'(done), 16'h0);

    // Back-to-back: go in the same cycle as done
    hdg_in = 12'h111; sqrs = 4'd0; error = 12'h000;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectLit("b2b_done", 16'(done), 16'h1);
    hdg_in = 12'h222;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectLit("b2b_hdg", 16'(dsrd_hdg), 16'h222);
    expectLit("b2b_busy", 16'(busy), 16'h1);
    error = 12'hFD0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectLit("neg48_hold", 16'(busy), 16'h1);
    error = 12'hFD1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectLit("neg47_done", 16'({busy, done}), 16'h1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
